// File: rtl/led_pattern_gen.sv
// LED pattern generator: a programmable prescaler steps one of four
// pattern modes (static, binary count, walking one, bouncing one).
module led_pattern_gen #(
    parameter int NUM_LEDS  = 8,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [NUM_LEDS-1:0]  pattern,
    output logic [NUM_LEDS-1:0]  leds,
    output logic                 tick
);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_COUNT  = 2'd1,
        M_WALK   = 2'd2,
        M_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic [DIV_WIDTH-1:0] ONE_D = 1;
    localparam logic [NUM_LEDS-1:0]  ONE_L = 1;

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_tick;
    logic [NUM_LEDS-1:0]  r_leds;
    dir_e                 r_dir;
    mode_e                r_mode_q;

    mode_e                w_mode;
    logic                 w_term;
    logic                 w_reload;
    logic [NUM_LEDS-1:0]  w_shl;
    logic [NUM_LEDS-1:0]  w_shr;
    logic [NUM_LEDS-1:0]  w_rot;
    logic [NUM_LEDS-1:0]  w_leds_nx;
    dir_e                 w_dir_nx;

    assign w_mode   = mode_e'(mode);
    // >= rather than == so a shrunken divisor never forces a full wrap
    assign w_term   = (r_cnt >= div);
    assign w_reload = (w_mode != r_mode_q);
    assign w_shl    = r_leds << 1;
    assign w_shr    = r_leds >> 1;
    assign w_rot    = w_shl | (r_leds >> (NUM_LEDS - 1));

    always_comb begin
        w_leds_nx = r_leds;
        w_dir_nx  = r_dir;
        if (w_reload) begin
            unique case (w_mode)
                M_STATIC: w_leds_nx = pattern;
                M_COUNT:  w_leds_nx = '0;
                M_WALK,
                M_BOUNCE: begin
                    w_leds_nx = ONE_L;
                    w_dir_nx  = DIR_UP;
                end
            endcase
        end else begin
            unique case (w_mode)
                M_STATIC: w_leds_nx = pattern;
                M_COUNT: begin
                    if (w_term) w_leds_nx = r_leds + ONE_L;
                end
                M_WALK: begin
                    if (w_term) w_leds_nx = w_rot;
                end
                M_BOUNCE: begin
                    // a single LED has nowhere to bounce to
                    if (w_term && NUM_LEDS > 1) begin
                        if (r_dir == DIR_UP) begin
                            w_leds_nx = w_shl;
                            if (w_shl[NUM_LEDS-1]) w_dir_nx = DIR_DN;
                        end else begin
                            w_leds_nx = w_shr;
                            if (w_shr[0]) w_dir_nx = DIR_UP;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_leds   <= '0;
            r_dir    <= DIR_UP;
            r_mode_q <= M_STATIC;
        end else if (en) begin
            r_cnt    <= w_term ? '0 : r_cnt + ONE_D;
            r_tick   <= w_term;
            r_leds   <= w_leds_nx;
            r_dir    <= w_dir_nx;
            r_mode_q <= w_mode;
        end else begin
            r_tick   <= 1'b0;
        end
    end

    assign leds = r_leds;
    assign tick = r_tick;

endmodule
